// File: rtl/ntt_intt_defines.sv
// ---------------------------------------------------------------------------
// ntt_intt_defines
//   Shared definitions for the NTT/INTT datapath blocks.
//   - LANES / ADDR_W : beat geometry (8 coefficients per beat, 9-bit address)
//   - state_t        : post-scale FSM encoding (IDLE / RUN / DRAIN)
//   - barrett_shift  : Barrett shift k for a given coefficient width
//   - barrett_const  : Barrett constant m = floor(2^k / Q)
// ---------------------------------------------------------------------------
package ntt_intt_defines;

  localparam int LANES  = 8;
  localparam int ADDR_W = 9;

  // Widest coefficient the constant helpers can handle.
  localparam int BARRETT_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // k equals the full product width, so every product p < 2^k gives
  // floor(p/Q) - 1 <= q_est <= floor(p/Q). One conditional subtract then
  // makes the result exact for any product, including inputs >= Q.
  function automatic int barrett_shift(input int coe_width);
    return 2 * coe_width;
  endfunction

  function automatic logic [2*BARRETT_MAX_W:0] barrett_const(input int q, input int coe_width);
    logic [2*BARRETT_MAX_W:0] num;
    logic [2*BARRETT_MAX_W:0] den;
    num = '0;
    num[barrett_shift(coe_width)] = 1'b1;
    den = '0;
    den[31:0] = q;
    return num / den;
  endfunction

endpackage

// File: rtl/intt_post_scale_if.sv
// ---------------------------------------------------------------------------
// intt_post_scale_if
//   Beat bus between the INTT core result port and the post-scale stage.
//   Handshake: valid-only. A beat transfers in every cycle its valid is high;
//   there is no ready and the consumer never stalls the producer.
//   i_valid / i_addr / i_data : beat into the scaler (core write strobe, address, 8 lanes)
//   o_valid / o_addr / o_data : scaled beat out of the scaler
//   Modports: master drives the i_* side (core / bench), slave is the scaler.
// ---------------------------------------------------------------------------
interface intt_post_scale_if #(
  parameter int COE_WIDTH = 39
);
  import ntt_intt_defines::*;

  logic                         i_valid;
  logic [ADDR_W-1:0]            i_addr;
  logic [LANES*COE_WIDTH-1:0]   i_data;
  logic                         o_valid;
  logic [ADDR_W-1:0]            o_addr;
  logic [LANES*COE_WIDTH-1:0]   o_data;

  modport master (
    output i_valid, i_addr, i_data,
    input  o_valid, o_addr, o_data
  );

  modport slave (
    input  i_valid, i_addr, i_data,
    output o_valid, o_addr, o_data
  );

endinterface

// File: rtl/mod_mul_const.sv
// ---------------------------------------------------------------------------
// mod_mul_const
//   One lane of y = (x * CONST) mod Q with PIP register stages.
//   Stage 1 registers the full 2*COE_WIDTH-bit product, stage 2 registers the
//   Barrett-reduced result; any further stages are plain delay registers.
//   Ports: clk, rst (async, active high), x (lane in), y (lane out).
// ---------------------------------------------------------------------------
module mod_mul_const
  import ntt_intt_defines::*;
#(
  parameter int COE_WIDTH = 39,
  parameter int Q         = 12289,
  parameter int CONST     = 12277,
  parameter int PIP       = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COE_WIDTH-1:0] x,
  output logic [COE_WIDTH-1:0] y
);

  localparam int             PW  = 2 * COE_WIDTH;
  localparam int             K   = barrett_shift(COE_WIDTH);
  localparam logic [PW-1:0]  M   = PW'(barrett_const(Q, COE_WIDTH));
  localparam logic [PW-1:0]  Q_P = PW'(Q);
  localparam logic [PW-1:0]  C_P = PW'(CONST);

  logic [PW-1:0]        prod_q;
  logic [PW-1:0]        q_est;
  logic [PW-1:0]        r_raw;
  logic [COE_WIDTH-1:0] red;
  logic [COE_WIDTH-1:0] stage_q [PIP-1];

  // q_est never exceeds p/Q, so q_est*Q fits in PW bits and r_raw is in [0, 2Q).
  always_comb begin
    q_est = PW'(((2*PW)'(prod_q) * (2*PW)'(M)) >> K);
    r_raw = prod_q - (q_est * Q_P);
    red   = COE_WIDTH'((r_raw >= Q_P) ? (r_raw - Q_P) : r_raw);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      for (int i = 0; i < PIP - 1; i++) stage_q[i] <= '0;
    end else begin
      prod_q     <= PW'(x) * C_P;
      stage_q[0] <= red;
      for (int i = 1; i < PIP - 1; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign y = stage_q[PIP-2];

endmodule

// File: rtl/intt_post_scale.sv
// ---------------------------------------------------------------------------
// intt_post_scale
//   Final INTT stage: scales all 8 lanes of each result beat by N^-1 mod Q,
//   delays the address to match, counts beats per polynomial and pulses
//   o_done with the last beat of a polynomial.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     i_start       start a polynomial: flush pipeline, zero count, enter RUN
//     bus (slave)   i_valid/i_addr/i_data in, o_valid/o_addr/o_data out
//     o_busy        high from i_start until the last beat has left
//     o_done        one-cycle pulse alongside the last beat's o_valid
//     o_overrun     sticky: a beat arrived while not accepting
//     o_range_err   sticky: an accepted lane was >= Q (INTT_SCALE_RANGE_CHECK_EN only)
//     o_state       current FSM state, for observation
//   Optional feature macro: INTT_SCALE_RANGE_CHECK_EN.
// ---------------------------------------------------------------------------
module intt_post_scale
  import ntt_intt_defines::*;
#(
  parameter int COE_WIDTH = 39,
  parameter int Q         = 12289,
  parameter int N_INV     = 12277,
  parameter int MUL_PIP   = 5,
  parameter int NUM_BEATS = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  intt_post_scale_if.slave       bus,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overrun,
`ifdef INTT_SCALE_RANGE_CHECK_EN
  output logic                   o_range_err,
`endif
  output state_t                 o_state
);

  localparam int CNT_W = $clog2(NUM_BEATS + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_base;
  logic [MUL_PIP-1:0] vld_q;
  logic [MUL_PIP-1:0] last_q;
  logic [ADDR_W-1:0]  addr_q [MUL_PIP];
  logic               accept;
  logic               is_last;
  logic               exit_last;
  logic               overrun_q;
  logic [LANES*COE_WIDTH-1:0] data_out;

  // A beat arriving with i_start belongs to the new polynomial, whatever the
  // current state; otherwise beats are only taken in RUN.
  assign accept    = bus.i_valid && (i_start || (state_q == RUN));
  assign cnt_base  = i_start ? '0 : cnt_q;
  assign is_last   = accept && (cnt_base == CNT_W'(NUM_BEATS - 1));
  assign exit_last = vld_q[MUL_PIP-1] && last_q[MUL_PIP-1];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      IDLE:  ;
      RUN:   if (is_last) state_d = DRAIN;
      DRAIN: if (exit_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_start) state_d = is_last ? DRAIN : RUN;
    o_busy = (state_q != IDLE);
    o_done = exit_last && (state_q == DRAIN);
  end

  assign o_state = state_q;

  // ---------------- beat counter, tag pipeline, sticky flags ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      vld_q     <= '0;
      last_q    <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < MUL_PIP; i++) addr_q[i] <= '0;
    end else begin
      if (i_start || accept) cnt_q <= cnt_base + {{(CNT_W-1){1'b0}}, accept};
      // i_start kills every in-flight tag; slot 0 takes the current beat.
      vld_q  <= {vld_q[MUL_PIP-2:0]  & {(MUL_PIP-1){~i_start}}, accept};
      last_q <= {last_q[MUL_PIP-2:0] & {(MUL_PIP-1){~i_start}}, is_last};
      addr_q[0] <= bus.i_addr;
      for (int i = 1; i < MUL_PIP; i++) addr_q[i] <= addr_q[i-1];
      if (i_start)                      overrun_q <= 1'b0;
      else if (bus.i_valid && !accept)  overrun_q <= 1'b1;
    end
  end

  assign o_overrun = overrun_q;

  // ---------------- lane multipliers ----------------
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mod_mul_const #(
      .COE_WIDTH (COE_WIDTH),
      .Q         (Q),
      .CONST     (N_INV),
      .PIP       (MUL_PIP)
    ) u_mul (
      .clk (clk),
      .rst (rst),
      .x   (bus.i_data[(k+1)*COE_WIDTH-1 -: COE_WIDTH]),
      .y   (data_out[(k+1)*COE_WIDTH-1 -: COE_WIDTH])
    );
  end

  assign bus.o_valid = vld_q[MUL_PIP-1];
  assign bus.o_addr  = addr_q[MUL_PIP-1];
  assign bus.o_data  = data_out;

`ifdef INTT_SCALE_RANGE_CHECK_EN
  localparam logic [COE_WIDTH-1:0] Q_W = COE_WIDTH'(Q);

  logic [LANES-1:0] lane_bad;
  logic             range_err_q;

  for (genvar k = 0; k < LANES; k++) begin : g_range
    assign lane_bad[k] = (bus.i_data[(k+1)*COE_WIDTH-1 -: COE_WIDTH] >= Q_W);
  end

  // A bad lane on the start beat belongs to the new polynomial, so it wins
  // over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         range_err_q <= 1'b0;
    else if (i_start)                range_err_q <= accept && (|lane_bad);
    else if (accept && (|lane_bad))  range_err_q <= 1'b1;
  end

  assign o_range_err = range_err_q;
`endif

endmodule

// File: tb/tb_intt_post_scale.sv
module tb_intt_post_scale;
  import ntt_intt_defines::*;

  localparam int W    = 14;
  localparam int QM   = 12289;
  localparam int NINV = 12277;
  localparam int PIP  = 5;
  localparam int NB   = 4;
  localparam int DW   = LANES * W;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                lane_in[8];
    int                lane_exp[8];
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;
    int                cyc;
    bit                last;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  logic   i_start;
  logic   o_busy, o_done, o_overrun;
  state_t o_state;
`ifdef INTT_SCALE_RANGE_CHECK_EN
  logic   o_range_err;
`endif

  always #5 clk = ~clk;

  intt_post_scale_if #(.COE_WIDTH(W)) bus ();

  intt_post_scale #(
    .COE_WIDTH (W),
    .Q         (QM),
    .N_INV     (NINV),
    .MUL_PIP   (PIP),
    .NUM_BEATS (NB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .bus         (bus.slave),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_overrun   (o_overrun),
`ifdef INTT_SCALE_RANGE_CHECK_EN
    .o_range_err (o_range_err),
`endif
    .o_state     (o_state)
  );

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_done   = 0;
  bit   m_run    = 1'b0;
  int   m_cnt    = 0;
  bit   m_ovr    = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] pack(input int l[8]);
    logic [DW-1:0] p;
    p = '0;
    for (int k = 0; k < LANES; k++) p[k*W +: W] = W'(l[k]);
    return p;
  endfunction

  function automatic logic [DW-1:0] model(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    longint        x;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      x = longint'(d[k*W +: W]);
      r[k*W +: W] = W'((x * NINV) % QM);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < LANES; k++) d[k*W +: W] = W'($urandom_range(0, QM - 1));
    return d;
  endfunction

  // ---------------- driver ----------------
  // Inputs change 1 ns after the rising edge and are sampled on the next one.
  task automatic drive(input bit st, input bit vl, input logic [ADDR_W-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] e);
    exp_t keep[$];
    exp_t ent;
    @(posedge clk);
    #1;
    i_start     = st;
    bus.i_valid = vl;
    bus.i_addr  = a;
    bus.i_data  = d;
    if (st) begin
      foreach (exp_q[i]) if (exp_q[i].cyc <= cyc) keep.push_back(exp_q[i]);
      exp_q = keep;
      m_run = 1'b1;
      m_cnt = 0;
      m_ovr = 1'b0;
    end
    if (vl) begin
      if (st || m_run) begin
        m_cnt++;
        ent.addr = a;
        ent.data = e;
        ent.cyc  = cyc + PIP;
        ent.last = (m_cnt == NB);
        if (ent.last) m_run = 1'b0;
        exp_q.push_back(ent);
      end else begin
        m_ovr = 1'b1;
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic send_rand(input bit st);
    logic [DW-1:0] d;
    d = rand_data();
    drive(st, 1'b1, ADDR_W'($urandom_range(0, 511)), d, model(d));
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = o_done;
    end
    chk(name, DW'(seen), DW'(1));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (o_done) n_done++;
      if (bus.o_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", DW'(bus.o_addr), DW'(0));
          n_err += (bus.o_addr == '0) ? 1 : 0;
        end else begin
          e = exp_q.pop_front();
          chk("out_data", bus.o_data, e.data);
          chk("out_addr", DW'(bus.o_addr), DW'(e.addr));
          chk("out_latency", DW'(cyc), DW'(e.cyc));
          chk("out_done", DW'(o_done), DW'(e.last));
        end
      end else if (o_done) begin
        chk("done_without_valid", DW'(o_done), DW'(0));
      end
    end
  end

  // ---------------- stimulus ----------------
  vec_t vecs[4];

  initial begin
    int done_before;

    vecs[0].addr = 9'd3;
    vecs[0].lane_in  = '{1, 1, 1, 1, 1, 1, 1, 1};
    vecs[0].lane_exp = '{12277, 12277, 12277, 12277, 12277, 12277, 12277, 12277};
    vecs[1].addr = 9'd7;
    vecs[1].lane_in  = '{0, 1, 1024, 12288, 2, 6144, 12277, 100};
    vecs[1].lane_exp = '{0, 12277, 1, 12, 12265, 6, 144, 11089};
    vecs[2].addr = 9'd0;
    vecs[2].lane_in  = '{3, 4096, 12, 5000, 12287, 11, 8192, 7};
    vecs[2].lane_exp = '{12253, 4, 12145, 1445, 24, 12157, 8, 12205};
    vecs[3].addr = 9'd511;
    vecs[3].lane_in  = '{12288, 0, 12288, 1, 12288, 2, 12288, 3};
    vecs[3].lane_exp = '{12, 0, 12, 12277, 12, 12265, 12, 12253};

    rst         = 1'b1;
    i_start     = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_addr  = '0;
    bus.i_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid",   DW'(bus.o_valid), DW'(0));
    chk("rst_addr",    DW'(bus.o_addr),  DW'(0));
    chk("rst_data",    bus.o_data,       DW'(0));
    chk("rst_busy",    DW'(o_busy),      DW'(0));
    chk("rst_done",    DW'(o_done),      DW'(0));
    chk("rst_overrun", DW'(o_overrun),   DW'(0));
    chk("rst_state",   DW'(o_state),     DW'(IDLE));
`ifdef INTT_SCALE_RANGE_CHECK_EN
    chk("rst_range_err", DW'(o_range_err), DW'(0));
`endif

    // Table vectors: one polynomial, gaps between some beats
    drive(1'b1, 1'b0, '0, '0, '0);
    for (int v = 0; v < 4; v++) begin
      drive(1'b0, 1'b1, vecs[v].addr, pack(vecs[v].lane_in), pack(vecs[v].lane_exp));
      if (v % 2 == 0) idle();
    end
    idle();
    wait_done("table_done");
    chk("busy_at_done", DW'(o_busy), DW'(1));
    @(negedge clk);
    chk("busy_after_done", DW'(o_busy), DW'(0));
    chk("no_overrun", DW'(o_overrun), DW'(0));

    // Back-to-back polynomial, beat 0 with i_start, 5th beat lands in DRAIN
    send_rand(1'b1);
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    send_rand(1'b0);
    idle();
    @(negedge clk);
    chk("drain_overrun", DW'(o_overrun), DW'(m_ovr));
    wait_done("b2b_done");
    @(negedge clk);
    chk("b2b_busy_fall", DW'(o_busy), DW'(0));
    send_rand(1'b0);
    idle();
    @(negedge clk);
    chk("idle_overrun", DW'(o_overrun), DW'(1));

    // Flush: start, two beats in flight, restart with a fresh 4-beat polynomial
    drive(1'b1, 1'b0, '0, '0, '0);
    send_rand(1'b0);
    @(negedge clk);
    chk("overrun_cleared", DW'(o_overrun), DW'(0));
    send_rand(1'b0);
    done_before = n_done;
    send_rand(1'b1);
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    idle();
    wait_done("flush_done");
    repeat (8) @(negedge clk);
    chk("single_done", DW'(n_done - done_before), DW'(1));
    chk("flush_queue_empty", DW'(exp_q.size()), DW'(0));

`ifdef INTT_SCALE_RANGE_CHECK_EN
    begin
      logic [DW-1:0] bad;
      bad = rand_data();
      bad[3*W +: W] = W'(QM);
      drive(1'b1, 1'b1, 9'd5, bad, '0);
      idle();
      @(negedge clk);
      chk("range_err_set", DW'(o_range_err), DW'(1));
      drive(1'b1, 1'b0, '0, '0, '0);
      idle();
      @(negedge clk);
      chk("range_err_cleared", DW'(o_range_err), DW'(0));
    end
`endif

    // Asynchronous reset while the first beat of a polynomial is on the output
    send_rand(1'b1);
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    idle();
    @(posedge clk);
    #1;
    chk("valid_before_rst", DW'(bus.o_valid), DW'(1));
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", DW'(bus.o_valid), DW'(0));
    chk("midrst_data",  bus.o_data,       DW'(0));
    chk("midrst_addr",  DW'(bus.o_addr),  DW'(0));
    chk("midrst_busy",  DW'(o_busy),      DW'(0));
    chk("midrst_done",  DW'(o_done),      DW'(0));
`ifdef INTT_SCALE_RANGE_CHECK_EN
    chk("midrst_range_err", DW'(o_range_err), DW'(0));
`endif
    exp_q.delete();
    m_run = 1'b0;
    m_cnt = 0;
    m_ovr = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_state", DW'(o_state), DW'(IDLE));
    chk("final_queue_empty", DW'(exp_q.size()), DW'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
